// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end. Issues word-aligned fetch requests to an
//   instruction memory and tags each accepted request with its PC. Returned
//   instructions are buffered in a 2-entry FIFO as {pc, data} for decode.
//   Redirects flush the FIFO and mark in-flight requests stale so that their
//   responses are dropped when they come back.
//
// Ports
//   clk, rst          : single clock; synchronous active-high reset
//   redirect          : taken branch/jump; flush and restart fetch this cycle
//   redirect_pc       : new fetch address (bits [1:0] ignored)
//   imem_req_valid    : fetch request valid
//   imem_req_addr     : fetch address (word aligned)
//   imem_req_ready    : memory accepts the request
//   imem_rsp_valid    : in-order response from memory
//   imem_rsp_data     : fetched instruction
//   instr_valid       : instruction available to decode
//   instr_ready       : decode consumes the instruction
//   instr, instr_pc   : FIFO head instruction and its address
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     imem_req_valid,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Control state
  logic [0:0]               state_q,    state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q,       pc_d;
  logic [1:0]               count_q,    count_d;
  logic [1:0]               inflight_q, inflight_d;
  logic [1:0]               discard_q,  discard_d;
  logic                     fifo_rd_q,  fifo_rd_d;
  logic                     fifo_wr_q,  fifo_wr_d;
  logic                     tag_rd_q,   tag_rd_d;
  logic                     tag_wr_q,   tag_wr_d;

  // Storage (not reset; qualified by the counters above)
  logic [ADDRESS_WIDTH-1:0] fifo_pc_q   [2];
  logic [ADDRESS_WIDTH-1:0] fifo_pc_d   [2];
  logic [DATA_WIDTH-1:0]    fifo_data_q [2];
  logic [DATA_WIDTH-1:0]    fifo_data_d [2];
  logic [ADDRESS_WIDTH-1:0] tag_pc_q    [2];
  logic [ADDRESS_WIDTH-1:0] tag_pc_d    [2];

  logic credit_ok;
  logic req_fire;
  logic rsp_fire;
  logic rsp_stale;
  logic push;
  logic pop;

  // The low redirect address bits are architecturally ignored.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit: FIFO entries plus outstanding requests (stale included) never
  // exceed the FIFO depth, so every live response always has a free slot.
  assign credit_ok      = ({1'b0, count_q} + {1'b0, inflight_q}) < 3'd2;
  assign imem_req_valid = !rst && !redirect && credit_ok;
  assign imem_req_addr  = pc_q;

  assign instr_valid    = !rst && !redirect && (count_q != 2'd0);
  assign instr          = rst ? '0 : fifo_data_q[fifo_rd_q];
  assign instr_pc       = rst ? '0 : fifo_pc_q[fifo_rd_q];

  assign req_fire  = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding cannot be matched to a tag; ignore it.
  assign rsp_fire  = !rst && imem_rsp_valid && (inflight_q != 2'd0);
  // A response in a redirect cycle is already stale: it belongs to a request
  // issued before the redirect.
  assign rsp_stale = redirect || (discard_q != 2'd0);
  assign push      = rsp_fire && !rsp_stale;
  assign pop       = instr_valid && instr_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;
    tag_rd_d    = tag_rd_q;
    tag_wr_d    = tag_wr_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_data_d = fifo_data_q;
    tag_pc_d    = tag_pc_q;

    // Tag queue holds the PC of every outstanding request, stale or not, so
    // it stays aligned with the in-order response stream.
    if (req_fire) begin
      tag_pc_d[tag_wr_q] = pc_q;
      tag_wr_d           = ~tag_wr_q;
      pc_d               = pc_q + ADDRESS_WIDTH'(4);
    end
    if (rsp_fire) begin
      tag_rd_d = ~tag_rd_q;
    end
    inflight_d = inflight_q + {1'b0, req_fire} - {1'b0, rsp_fire};

    if (push) begin
      fifo_pc_d[fifo_wr_q]   = tag_pc_q[tag_rd_q];
      fifo_data_d[fifo_wr_q] = imem_rsp_data;
      fifo_wr_d              = ~fifo_wr_q;
    end
    if (pop) begin
      fifo_rd_d = ~fifo_rd_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if (redirect) begin
      // No issue and no pop happen this cycle, so everything still
      // outstanding after this cycle's response is stale.
      count_d   = 2'd0;
      fifo_wr_d = fifo_rd_q;
      discard_d = inflight_q - {1'b0, rsp_fire};
      pc_d      = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (rsp_fire && (discard_q != 2'd0)) begin
      discard_d = discard_q - 2'd1;
    end

    case (state_q)
      ST_RUN:   if (discard_d != 2'd0) state_d = ST_DRAIN;
      ST_DRAIN: if (discard_d == 2'd0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      inflight_q <= 2'd0;
      discard_q  <= 2'd0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      tag_rd_q   <= 1'b0;
      tag_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_data_q <= fifo_data_d;
    tag_pc_q    <= tag_pc_d;
  end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int          DW  = 32;
  localparam int          AW  = 16;
  localparam logic [15:0] RPC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  typedef struct packed {logic [15:0] pc; logic [31:0] data;} item_t;
  typedef struct {logic [15:0] addr; int due;} mreq_t;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a} ^ 32'h3C5A_96E1;
  endfunction

  // ---------------- memory model ----------------
  mreq_t       memq[$];
  int          cyc      = 0;
  int          last_due = 0;
  int unsigned lat_min  = 1;
  int unsigned lat_max  = 1;
  int unsigned rdy_pct  = 100;

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(memq[0].addr);
        memq.delete(0);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  // Program-order view: expected deliveries are the accepted fetch addresses
  // since the last redirect/reset, in order. stale_out counts old requests
  // whose responses must be thrown away; arrived counts live responses
  // already buffered and not yet consumed.
  logic [15:0] model_pc = RPC;
  item_t       exp_q[$];
  int          stale_out = 0;
  int          arrived   = 0;
  int          acc_cnt   = 0;
  logic        exp_rv;
  logic        exp_iv;
  int          due;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid",   64'(imem_req_valid), 64'(0));
      chk("rst_instr_valid", 64'(instr_valid),    64'(0));
      chk("rst_instr",       64'(instr),          64'(0));
      chk("rst_instr_pc",    64'(instr_pc),       64'(0));
      model_pc  = RPC;
      exp_q.delete();
      stale_out = 0;
      arrived   = 0;
    end else begin
      exp_rv = !redirect && ((exp_q.size() + stale_out) < 2);
      exp_iv = !redirect && (arrived > 0);
      chk("req_valid",   64'(imem_req_valid), 64'(exp_rv));
      chk("instr_valid", 64'(instr_valid),    64'(exp_iv));
      if (redirect) begin
        stale_out = memq.size();
        exp_q.delete();
        arrived   = 0;
        model_pc  = {redirect_pc[15:2], 2'b00};
      end else begin
        if (imem_rsp_valid) begin
          if (stale_out > 0) stale_out--;
          else arrived++;
        end
        if (exp_iv && instr_ready) arrived--;
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", 64'(imem_req_addr), 64'(model_pc));
          exp_q.push_back('{model_pc, mem_word(model_pc)});
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          memq.push_back('{model_pc, due});
          model_pc = model_pc + 16'd4;
          acc_cnt++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  item_t       e;
  logic        hold = 1'b0;
  logic [31:0] hold_instr;
  logic [15:0] hold_pc;
  int          delivered = 0;

  always @(negedge clk) begin
    #1;
    if (!rst && !redirect && hold) begin
      chk("hold_valid",    64'(instr_valid), 64'(1));
      chk("hold_instr",    64'(instr),       64'(hold_instr));
      chk("hold_instr_pc", 64'(instr_pc),    64'(hold_pc));
    end
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_instr: got pc %0h, required no delivery (t=%0t)", instr_pc, $time);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", 64'(instr_pc), 64'(e.pc));
        chk("instr",    64'(instr),    64'(e.data));
        delivered++;
      end
    end
    hold       = !rst && instr_valid && !instr_ready;
    hold_instr = instr;
    hold_pc    = instr_pc;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset(input int n);
    redirect = 1'b0;
    rst      = 1'b1;
    step(n);
    rst      = 1'b0;
  endtask

  int   a0;
  logic found;

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    step(4);
    rst         = 1'b0;
    instr_ready = 1'b1;
    step(30);

    // Backpressure from a clean restart point.
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step(1);
    redirect = 1'b0;
    a0 = acc_cnt;
    step(12);
    chk("bp_accepts",     64'(acc_cnt - a0), 64'(2));
    chk("bp_req_valid",   64'(imem_req_valid), 64'(0));
    chk("bp_instr_valid", 64'(instr_valid),    64'(1));
    instr_ready = 1'b1;
    step(12);

    // Redirect with two requests outstanding at latency 3.
    lat_min = 3; lat_max = 3;
    step(8);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (memq.size() == 2) found = 1'b1;
      else step(1);
    end
    chk("two_inflight_seen", 64'(found), 64'(1));
    redirect    = 1'b1;
    redirect_pc = 16'h0102;
    step(1);
    redirect = 1'b0;
    step(20);

    // Address wrap through 0xFFFC -> 0x0000.
    lat_min = 1; lat_max = 1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFA;
    step(1);
    redirect = 1'b0;
    step(15);

    // Redirect coinciding with a response and a decode handshake.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (imem_rsp_valid && instr_valid && instr_ready) begin
        found       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
      end
      step(1);
    end
    redirect = 1'b0;
    chk("simul_event_seen", 64'(found), 64'(1));
    step(10);

    // Reset with the FIFO full.
    instr_ready = 1'b0;
    step(10);
    chk("full_before_rst", 64'(instr_valid), 64'(1));
    do_reset(2);
    instr_ready = 1'b1;
    step(10);

    // Reset while a response is still in flight (arrives during rst).
    lat_min = 3; lat_max = 3;
    instr_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (arrived >= 1 && memq.size() >= 1) found = 1'b1;
      else step(1);
    end
    chk("late_rsp_setup", 64'(found), 64'(1));
    do_reset(6);
    instr_ready = 1'b1;
    step(10);

    // Randomized traffic.
    rdy_pct = 70;
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      instr_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 1) begin
        do_reset(6);
      end else if ($urandom_range(99) < 4) begin
        redirect    = 1'b1;
        redirect_pc = 16'($urandom);
        step(1);
      end else begin
        redirect = 1'b0;
        step(1);
      end
    end
    redirect = 1'b0;
    step(5);
    chk("delivered_some", 64'(delivered > 100), 64'(1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
